// File: rtl/dbg_display_pkg.sv
// Shared encodings for the debug display: source modes, blanking constants and
// the active-low hex-to-segment table ({dp,g,f,e,d,c,b,a}, dp kept off).
package dbg_display_pkg;

   typedef enum logic [1:0] {
      MODE_PC    = 2'd0,
      MODE_REG   = 2'd1,
      MODE_AUTO  = 2'd2,
      MODE_BLANK = 2'd3
   } mode_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Entry n is the pattern for hex digit n (entry 15 is written first).
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/dbg_display_if.sv
// Debug port between the CPU core and the display controller: the display
// selects a register and observes the PC and the selected register's data.
interface dbg_display_if;

   logic [31:0] PC;
   logic [31:0] reg_data;
   logic [4:0]  reg_sel;

   modport master (input PC, input reg_data, output reg_sel);
   modport slave  (output PC, output reg_data, input reg_sel);

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low 7-segment pattern decoder {g,f,e,d,c,b,a}.
module hex7seg
   import dbg_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i][6:0];

endmodule

// File: rtl/dbg_display.sv
// Multiplexed 8-digit hex debug display fed from the core's PC or registers.
// Optional debounced single-step pulse when DBG_DISP_STEP_EN is defined.
module dbg_display
   import dbg_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int AUTO_DIV    = 50000000,
   parameter int DEB_CYCLES  = 1000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    mode_i,
   input  logic [4:0]    sw_sel_i,
   dbg_display_if.master dbg,
   output logic [7:0]    an_o,
   output logic [7:0]    seg_o
`ifdef DBG_DISP_STEP_EN
   ,
   input  logic          step_btn_i,
   output logic          cpu_step_o
`endif
);

   localparam int DW = $clog2(REFRESH_DIV);
   localparam int AW = $clog2(AUTO_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);

   if (REFRESH_DIV < 2 || AUTO_DIV < 2 || DEB_CYCLES < 2) begin : g_bad_params
      $error("dbg_display: REFRESH_DIV, AUTO_DIV and DEB_CYCLES must be >= 2");
   end

   mode_e mode;
   assign mode = mode_e'(mode_i);

   logic [DW-1:0] divCnt_q, divCnt_d;
   logic [2:0]    dig_q, dig_d, digNext;
   logic [31:0]   shadow_q, shadow_d, frameSrc;
   logic [7:0]    an_q, an_d, seg_q, seg_d;
   logic [4:0]    regSel_q, regSel_d, autoIdx_q, autoIdx_d;
   logic [AW-1:0] autoCnt_q, autoCnt_d;
   logic          tick;
   logic [3:0]    nibble;
   logic [6:0]    hexSeg;

   hex7seg u_hex7seg (
      .nibble_i (nibble),
      .seg_o    (hexSeg)
   );

   // The displayed nibble comes from shadow_d so the latch tick already shows the new frame.
   always_comb begin
      tick     = (divCnt_q == DIV_LAST);
      divCnt_d = tick ? '0 : divCnt_q + DW'(1);
      digNext  = dig_q + 3'd1;
      dig_d    = tick ? digNext : dig_q;

      case (mode)
         MODE_PC:             frameSrc = dbg.PC;
         MODE_REG, MODE_AUTO: frameSrc = dbg.reg_data;
         default:             frameSrc = '0;
      endcase
      shadow_d = (tick && digNext == 3'd0) ? frameSrc : shadow_q;
      nibble   = shadow_d[{digNext, 2'b00} +: 4];

      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         if (mode == MODE_BLANK) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
         end else begin
            an_d  = ~(8'b1 << digNext);
            seg_d = {1'b1, hexSeg};
         end
      end

      autoCnt_d = autoCnt_q;
      autoIdx_d = autoIdx_q;
      if (mode == MODE_AUTO) begin
         if (autoCnt_q == AUTO_LAST) begin
            autoCnt_d = '0;
            autoIdx_d = autoIdx_q + 5'd1;
         end else begin
            autoCnt_d = autoCnt_q + AW'(1);
         end
      end

      regSel_d = (mode == MODE_REG) ? sw_sel_i : autoIdx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt_q  <= '0;
         dig_q     <= 3'd7;
         shadow_q  <= '0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_BLANK;
         regSel_q  <= '0;
         autoIdx_q <= '0;
         autoCnt_q <= '0;
      end else begin
         divCnt_q  <= divCnt_d;
         dig_q     <= dig_d;
         shadow_q  <= shadow_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         regSel_q  <= regSel_d;
         autoIdx_q <= autoIdx_d;
         autoCnt_q <= autoCnt_d;
      end
   end

   assign an_o        = an_q;
   assign seg_o       = seg_q;
   assign dbg.reg_sel = regSel_q;

`ifdef DBG_DISP_STEP_EN
   localparam int BW = $clog2(DEB_CYCLES);
   localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [BW-1:0] debCnt_q, debCnt_d;
   logic          debLevel_q, debLevel_d;
   logic          cpuStep_q, cpuStep_d;

   // Any cycle where the synchronized input agrees with the level restarts the count.
   always_comb begin
      debCnt_d   = '0;
      debLevel_d = debLevel_q;
      if (sync_q[1] != debLevel_q) begin
         if (debCnt_q == DEB_LAST) begin
            debLevel_d = sync_q[1];
         end else begin
            debCnt_d = debCnt_q + BW'(1);
         end
      end
      cpuStep_d = debLevel_d & ~debLevel_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         debCnt_q   <= '0;
         debLevel_q <= 1'b0;
         cpuStep_q  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], step_btn_i};
         debCnt_q   <= debCnt_d;
         debLevel_q <= debLevel_d;
         cpuStep_q  <= cpuStep_d;
      end
   end

   assign cpu_step_o = cpuStep_q;
`endif

endmodule

// File: tb/tb_dbg_display.sv
// Self-checking bench for dbg_display: hand-derived frame vectors, corner-case
// sequences and a randomized run against a behavioural model of the display.
module tb_dbg_display;

   localparam int RD = 4;
   localparam int AD = 16;
   localparam int DC = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic [4:0]  swSel = 5'd0;
   logic [31:0] pcVal = 32'd0;
   logic [7:0]  an, seg;
   logic [31:0] regFile [32];
   logic        chkEn = 1'b0;
   int          nChecks = 0;
   int          nFail = 0;

   dbg_display_if dbg ();
   assign dbg.PC       = pcVal;
   assign dbg.reg_data = regFile[dbg.reg_sel];

`ifdef DBG_DISP_STEP_EN
   logic stepBtn = 1'b0;
   logic cpuStep;
   int   pulses = 0;
`endif

   dbg_display #(.REFRESH_DIV(RD), .AUTO_DIV(AD), .DEB_CYCLES(DC)) dut (
      .clk      (clk),
      .rst      (rst),
      .mode_i   (mode),
      .sw_sel_i (swSel),
      .dbg      (dbg),
      .an_o     (an),
      .seg_o    (seg)
`ifdef DBG_DISP_STEP_EN
      ,
      .step_btn_i (stepBtn),
      .cpu_step_o (cpuStep)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] segOf(input logic [3:0] n);
      case (n)
         4'h0: segOf = 8'hC0;  4'h1: segOf = 8'hF9;  4'h2: segOf = 8'hA4;  4'h3: segOf = 8'hB0;
         4'h4: segOf = 8'h99;  4'h5: segOf = 8'h92;  4'h6: segOf = 8'h82;  4'h7: segOf = 8'hF8;
         4'h8: segOf = 8'h80;  4'h9: segOf = 8'h90;  4'hA: segOf = 8'h88;  4'hB: segOf = 8'h83;
         4'hC: segOf = 8'hC6;  4'hD: segOf = 8'hA1;  4'hE: segOf = 8'h86;  4'hF: segOf = 8'h8E;
         default: segOf = 8'hFF;
      endcase
   endfunction

   // Reference model: timing comes from a count of edges since reset, the scan index
   // from total time spent in auto mode, and the latch reads the register selected last cycle.
   int          edges = 0;
   int          autoCycles = 0;
   int          mDigit;
   logic [31:0] mShadow = '0;
   logic [7:0]  mAn = 8'hFF, mSeg = 8'hFF;
   logic [4:0]  mRegSel = '0, newSel;

   always @(posedge clk) begin
      if (rst) begin
         edges = 0; autoCycles = 0; mShadow = '0;
         mAn = 8'hFF; mSeg = 8'hFF; mRegSel = '0;
      end else begin
         edges++;
         if (edges % RD == 0) begin
            mDigit = (edges / RD + 7) % 8;
            if (mDigit == 0)
               mShadow = (mode == 2'd0) ? pcVal : (mode == 2'd3) ? 32'd0 : regFile[mRegSel];
            if (mode == 2'd3) begin
               mAn = 8'hFF; mSeg = 8'hFF;
            end else begin
               mAn  = ~(8'h01 << mDigit);
               mSeg = segOf(mShadow[4*mDigit +: 4]);
            end
         end
         newSel = (mode == 2'd1) ? swSel : 5'((autoCycles / AD) % 32);
         if (mode == 2'd2) autoCycles++;
         mRegSel = newSel;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Continuous comparison of every output against the model on the falling edge.
   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("model_an", {24'd0, an}, {24'd0, mAn});
         checkOutput("model_seg", {24'd0, seg}, {24'd0, mSeg});
         checkOutput("model_reg_sel", {27'd0, dbg.reg_sel}, {27'd0, mRegSel});
      end
   end

`ifdef DBG_DISP_STEP_EN
   always @(negedge clk) if (cpuStep === 1'b1) pulses++;
`endif

   task automatic applyStimulus(input logic [1:0] m, input logic [4:0] s, input logic [31:0] p);
      @(negedge clk);
      mode = m; swSel = s; pcVal = p;
   endtask

   task automatic doReset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]       mode;
      logic [4:0]       sel;
      logic [31:0]      pc;
      logic [31:0]      rv;
      logic [7:0][7:0]  expSeg;
   } vec_t;

   vec_t vecs [6];

   initial begin
      for (int i = 0; i < 32; i++) regFile[i] = $urandom;

      vecs[0] = '{mode: 2'd0, sel: 5'd0, pc: 32'h0040_1234, rv: 32'h0,
                  expSeg: {8'hC0, 8'hC0, 8'h99, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{mode: 2'd1, sel: 5'd5, pc: 32'h0, rv: 32'hDEAD_BEEF,
                  expSeg: {8'hA1, 8'h86, 8'h88, 8'hA1, 8'h83, 8'h86, 8'h86, 8'h8E}};
      vecs[2] = '{mode: 2'd0, sel: 5'd3, pc: 32'h7654_3210, rv: 32'h0,
                  expSeg: {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}};
      vecs[3] = '{mode: 2'd1, sel: 5'd9, pc: 32'h1111_1111, rv: 32'hFEDC_BA98,
                  expSeg: {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}};
      vecs[4] = '{mode: 2'd3, sel: 5'd0, pc: 32'h0040_1234, rv: 32'h0,
                  expSeg: {8{8'hFF}}};
      vecs[5] = '{mode: 2'd2, sel: 5'd0, pc: 32'h0, rv: 32'h1357_9BDF,
                  expSeg: {8'hF9, 8'hB0, 8'h92, 8'hF8, 8'h90, 8'h83, 8'hA1, 8'h8E}};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_an", {24'd0, an}, 32'hFF);
      checkOutput("reset_seg", {24'd0, seg}, 32'hFF);
      checkOutput("reset_reg_sel", {27'd0, dbg.reg_sel}, 32'd0);
      chkEn = 1'b1;

      // Table: reset with fixed inputs, then read the first frame digit by digit.
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].mode, vecs[v].sel, vecs[v].pc);
         regFile[vecs[v].sel] = vecs[v].rv;
         doReset(2);
         for (int c = 0; c < RD - 1; c++) begin
            @(negedge clk);
            checkOutput("pre_tick_an", {24'd0, an}, 32'hFF);
         end
         for (int k = 0; k < 8; k++) begin
            repeat ((k == 0) ? 1 : RD) @(negedge clk);
            checkOutput("vec_an", {24'd0, an},
                        (vecs[v].mode == 2'd3) ? 32'hFF : {24'd0, ~(8'h01 << k)});
            checkOutput("vec_seg", {24'd0, seg}, {24'd0, vecs[v].expSeg[k]});
         end
      end

      // Auto-scan advance and wrap of the register index.
      applyStimulus(2'd2, 5'd0, 32'h0);
      doReset(2);
      repeat (16) @(negedge clk);
      checkOutput("auto_sel_16", {27'd0, dbg.reg_sel}, 32'd0);
      @(negedge clk);
      checkOutput("auto_sel_17", {27'd0, dbg.reg_sel}, 32'd1);
      repeat (16) @(negedge clk);
      checkOutput("auto_sel_33", {27'd0, dbg.reg_sel}, 32'd2);
      repeat (464) @(negedge clk);
      checkOutput("auto_sel_31", {27'd0, dbg.reg_sel}, 32'd31);
      repeat (16) @(negedge clk);
      checkOutput("auto_sel_wrap", {27'd0, dbg.reg_sel}, 32'd0);

      // One-cycle reg_sel latency from the switch input.
      mode = 2'd1; swSel = 5'd7;
      @(negedge clk);
      checkOutput("sw_sel_latency", {27'd0, dbg.reg_sel}, 32'd7);

      // PC change mid-frame keeps the old frame; blanking acts at the next tick.
      applyStimulus(2'd0, 5'd0, 32'h1234_5678);
      doReset(2);
      repeat (16) @(negedge clk);
      pcVal = 32'hFFFF_FFFF;
      repeat (4) @(negedge clk);
      checkOutput("mid_pc_an", {24'd0, an}, 32'hEF);
      checkOutput("mid_pc_seg", {24'd0, seg}, 32'h99);
      mode = 2'd3;
      repeat (4) @(negedge clk);
      checkOutput("blank_an", {24'd0, an}, 32'hFF);
      checkOutput("blank_seg", {24'd0, seg}, 32'hFF);
      mode = 2'd0;
      repeat (4) @(negedge clk);
      checkOutput("unblank_seg", {24'd0, seg}, 32'hA4);
      repeat (4) @(negedge clk);
      checkOutput("old_frame_seg", {24'd0, seg}, 32'hF9);
      repeat (4) @(negedge clk);
      checkOutput("new_frame_an", {24'd0, an}, 32'hFE);
      checkOutput("new_frame_seg", {24'd0, seg}, 32'h8E);

      // Reset pulsed while digit 5 is lit.
      applyStimulus(2'd0, 5'd0, 32'h0040_1234);
      doReset(2);
      repeat (24) @(negedge clk);
      checkOutput("dig5_an", {24'd0, an}, 32'hDF);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_an", {24'd0, an}, 32'hFF);
      checkOutput("midrst_seg", {24'd0, seg}, 32'hFF);
      rst = 1'b0;
      repeat (RD - 1) @(negedge clk);
      checkOutput("midrst_wait_an", {24'd0, an}, 32'hFF);
      @(negedge clk);
      checkOutput("midrst_first_an", {24'd0, an}, 32'hFE);
      checkOutput("midrst_first_seg", {24'd0, seg}, 32'h99);

      // Randomized run checked only by the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) swSel = 5'($urandom);
         if ($urandom_range(0, 9) == 0) pcVal = $urandom;
         if ($urandom_range(0, 3) == 0) regFile[$urandom_range(0, 31)] = $urandom;
         rst = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      rst = 1'b0;

`ifdef DBG_DISP_STEP_EN
      repeat (20) @(negedge clk);
      pulses = 0;
      for (int b = 0; b < 5; b++) begin
         stepBtn = ~b[0];
         @(negedge clk);
      end
      stepBtn = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("step_one_pulse", pulses, 32'd1);
      stepBtn = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("step_release", pulses, 32'd1);
      stepBtn = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("step_second_press", pulses, 32'd2);
`endif

      chkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/dbg_display.md
# dbg_display

Board-level debug display controller downstream of the single-cycle CPU core. It drives the core's debug register-select port and consumes the core's PC and selected-register data. It shows a chosen 32-bit value as eight hex digits on a multiplexed, active-low 7-segment display. Optionally it generates a debounced single-step pulse that the top level uses as the core's clock enable.

## Interface
Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (≥2).
- AUTO_DIV, 50000000: clk cycles per register advance in auto-scan mode (≥2).
- DEB_CYCLES, 1000000: stable-level cycles required by the step debouncer (≥2; used only with the step macro).

Ports:
- clk  in  1  system clock, same clock as the CPU core.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  display source: 0 = PC, 1 = register sw_sel, 2 = auto-scan registers, 3 = blank.
- sw_sel  in  5  register index used in mode 1.
- PC  in  32  core program counter.
- reg_data  in  32  core register data for reg_sel; combinational from the core.
- reg_sel  out  5  register index driven to the core.
- an  out  8  digit anodes, active-low; an[7] is the leftmost digit.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- step_btn  in  1  raw step push-button (macro only).
- cpu_step  out  1  one-cycle step pulse (macro only).

## Operation
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps. tick = (div_cnt == REFRESH_DIV-1).
- Digit index: dig (0..7) advances by one on each tick, and 7 wraps to 0.
- Shadow latch: on a tick where the next dig is 0, shadow is loaded from the source selected by mode (PC for mode 0; reg_data for modes 1 and 2; 0 for mode 3). The frame therefore never tears.
- Mode changes take effect at the next frame latch, except blanking. Blanking follows the mode input at each tick.
- Each tick registers the outputs:
  - In modes 0–2: an = ~(8'b1 << next dig), and seg = the hex pattern of shadow nibble [4·next dig +: 4] with dp = 1 (off).
  - In mode 3: an = 8'hFF and seg = 8'hFF.
- reg_sel is registered every cycle: sw_sel when mode = 1, otherwise auto_idx.
- auto_idx counts only in mode 2. auto_cnt counts 0..AUTO_DIV-1. At wrap, auto_idx increments and 31 wraps to 0. Outside mode 2, both auto_cnt and auto_idx hold their values.
- Hex patterns (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
Reset values:
- div_cnt = 0, dig = 7, shadow = 0.
- an = 8'hFF, seg = 8'hFF.
- reg_sel = 0, auto_idx = 0, auto_cnt = 0.
- cpu_step = 0.

Latencies and cycle behaviour:
- The first tick occurs REFRESH_DIV cycles after rst deasserts. That tick latches shadow and lights digit 0 (an = 8'hFE).
- Full frame = 8·REFRESH_DIV cycles.
- reg_sel follows sw_sel or auto_idx with one cycle of latency.
- reg_data is sampled in the same cycle as the latch tick. If reg_sel changed on the cycle before the tick, the latch captures the new register.
- rst asserted mid-frame forces all reset values on the next edge. The divider and the scan restart from scratch.
- An auto_idx wrap coinciding with a latch tick: the latch captures the data for the old reg_sel. The new index is visible at the next frame.

## Configuration
- Macro DBG_DISP_STEP_EN.
- Defined:
  - step_btn passes through a 2-flop synchronizer, then the debouncer.
  - The debounced level updates only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - cpu_step is high for exactly one cycle on the cycle after the debounced level rises 0→1. Holding the button produces no further pulses.
- Undefined: the step_btn and cpu_step ports and all step logic are absent. The top level runs the core free.

## Structure
- Package dbg_display_pkg holds:
  - the mode encodings: MODE_PC, MODE_REG, MODE_AUTO, MODE_BLANK;
  - the 16-entry hex-to-segment constant table;
  - SEG_BLANK = 8'hFF and AN_OFF = 8'hFF.
- One sub-module: hex7seg, a combinational 4-bit nibble to 7-bit active-low pattern decoder. It is instantiated once, on the selected nibble.

## Test plan
All scenarios use REFRESH_DIV = 4, AUTO_DIV = 16, DEB_CYCLES = 8.
- Reset release with mode 0 and PC = 32'h0040_1234 → an = FF for 4 cycles; then digit 0 lights with seg = 99 ("4"); over the next ticks the digits read 4, 3, 2, 1, 0, 4, 0, 0 (digit 0 to digit 7).
- Mode 1, sw_sel = 5, the core returns 32'hDEAD_BEEF for register 5 → reg_sel = 5 one cycle later; the next frame shows F, E, E, b, d, A, E, d on digits 0 to 7.
- Mode 2 held for 40 cycles → reg_sel = 0, then 1 at cycle 16, then 2 at cycle 32; with auto_idx preset to 31, the next wrap gives reg_sel = 0.
- PC changes mid-frame → the digits keep the old value until the dig-0 latch; mode 3 set mid-frame → an = FF at the next tick.
- rst pulsed at digit 5 → on the next edge an = FF and dig = 7; the first tick after rst deasserts shows digit 0.
- With DBG_DISP_STEP_EN: step_btn bouncing for 5 cycles, then held high for 20 cycles → exactly one cpu_step pulse. Re-run without the macro: the model compiles with no step ports.
